lcd_frame_arbiter: RTL and testbench
====================================

Name: lcd_frame_arbiter

Overview:
- Shares the single 16x2 character LCD driver between two frame producers, requester 0 and requester 1.
- Each producer presents two 128-bit lines of 16 ASCII characters, MSB = leftmost character, and raises a request.
- The arbiter grants round-robin, latches the winning frame into the line registers that feed the LCD driver, and starts a refresh.
- After the refresh it holds that frame on screen for a minimum dwell time before it grants again.

Parameters:
- HOLD_CYCLES, 50000000: minimum dwell after a refresh completes, in clk cycles; legal range 1 .. 2^26-1.
- ACCEPT_TIMEOUT, 16: cycles to wait for drv_busy to rise after drv_start; legal range 1 .. 255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 frame request
- line1_0  in  128  requester 0 top line
- line2_0  in  128  requester 0 bottom line
- ack0  out  1  one-cycle grant/accept pulse to requester 0
- req1  in  1  requester 1 frame request
- line1_1  in  128  requester 1 top line
- line2_1  in  128  requester 1 bottom line
- ack1  out  1  one-cycle grant/accept pulse to requester 1
- drv_busy  in  1  LCD driver is writing
- drv_start  out  1  one-cycle refresh start pulse to the LCD driver
- line1  out  128  registered top line to the LCD driver
- line2  out  128  registered bottom line to the LCD driver
- owner  out  1  index of the last granted requester
- hold_active  out  1  high while in HOLD
- timeout_err  out  1  sticky flag: driver failed to accept a start

Behaviour:
- All outputs are registered. State and outputs update only on posedge clk.
- Reset values:
  - state = IDLE
  - line1 = line2 = 128'h20202020202020202020202020202020 (all spaces)
  - ack0 = ack1 = drv_start = hold_active = timeout_err = 0
  - owner = 0
  - internal last_grant = 1, so req0 wins the first tie
  - all counters = 0
- Reset asserted in any state, mid-refresh included, applies these values on the next edge. Nothing is completed or preserved.
- Requester handshake:
  - Requester holds req high and its lines stable until it sees ack.
  - ack is a single cycle. On the cycle that ack is high, the lines are sampled into line1/line2.
  - A req still high in a later IDLE is treated as a new request.
- Round-robin:
  - Only one req high: that requester wins.
  - Both high: the requester != last_grant wins.
  - last_grant and owner update on every grant.
- IDLE:
  - Grant only when drv_busy = 0 and (req0 | req1) at edge k.
  - At edge k: load line1/line2 from the winner, set ack_winner = 1, drv_start = 1, owner = winner; go to START.
  - drv_busy = 1 in IDLE: no grant, requests wait.
- START (one cycle): at the next edge clear ack and drv_start, clear the accept counter, go to WAIT_ACCEPT.
  - Latency: req sampled at edge k; ack and drv_start visible in cycle k+1 and low again from k+2.
- WAIT_ACCEPT:
  - drv_busy = 1: go to WAIT_DONE.
  - Otherwise increment the accept counter. When it reaches ACCEPT_TIMEOUT, set timeout_err = 1 and go to HOLD.
  - drv_busy high on the same edge the counter reaches ACCEPT_TIMEOUT: accept wins, no error.
- WAIT_DONE: stay while drv_busy = 1. On drv_busy = 0, clear the hold counter, set hold_active = 1, go to HOLD. No timeout in this state.
- HOLD:
  - Hold counter increments each cycle.
  - When counter == HOLD_CYCLES-1: clear hold_active and return to IDLE, so exactly HOLD_CYCLES cycles are spent in HOLD.
  - req inputs are ignored. Grants resume from IDLE on the following edge.
- line1/line2 change only on a grant edge or on reset. They are stable for the whole refresh and dwell.
- timeout_err is cleared only by reset.
- req0/req1 dropping before ack (protocol violation): that requester is not granted if its req is low at the sampling edge. No other effect.

Test Plan:
- Reset then idle: after reset, line1 = line2 = all 0x20, owner = 0, all pulses low. Hold reset 3 cycles mid-HOLD; state must return to IDLE with hold_active = 0.
- Single grant, HOLD_CYCLES=4: req0 with line1_0 = "HELLO WORLD     " and drv_busy low at edge k.
  - ack0 and drv_start are high for cycle k+1 only, and line1 = "HELLO WORLD     ".
  - drv_busy goes high 2 cycles later and low 5 cycles later.
  - hold_active is high for exactly 4 cycles, then IDLE.
- Round-robin tie: req0 and req1 both held high continuously, with the driver model responding.
  - Grant order is 0, 1, 0, 1.
  - owner toggles accordingly, and ack0/ack1 are never high together.
- Busy blocking: drv_busy forced high, req1 raised. No ack1 and no drv_start while busy. After busy drops, ack1 fires on the cycle after the first sampled low.
- Timeout, ACCEPT_TIMEOUT=3: driver never asserts busy.
  - timeout_err goes to 1 exactly 3 cycles after entering WAIT_ACCEPT, then HOLD, then IDLE.
  - timeout_err stays 1 across a subsequent normal grant and clears only on reset.
- Requests during HOLD: req1 raised while in HOLD is ignored until HOLD ends. ack1 is high in the first cycle after the IDLE sampling edge, and line1/line2 do not change during HOLD.

Source files
------------

// File: rtl/lcd_frame_arbiter.sv
// Round-robin arbiter sharing one 16x2 LCD driver between two frame producers.
// A granted frame is latched, refreshed, then held on screen for a minimum dwell.
module lcd_frame_arbiter #(
   parameter int unsigned HOLD_CYCLES    = 50000000,
   parameter int unsigned ACCEPT_TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic [127:0] line1_0,
   input  logic [127:0] line2_0,
   output logic         ack0,
   input  logic         req1,
   input  logic [127:0] line1_1,
   input  logic [127:0] line2_1,
   output logic         ack1,
   input  logic         drv_busy,
   output logic         drv_start,
   output logic [127:0] line1,
   output logic [127:0] line2,
   output logic         owner,
   output logic         hold_active,
   output logic         timeout_err
);

   typedef enum logic [2:0] {StIdle, StStart, StWaitAccept, StWaitDone, StHold} state_e;

   localparam logic [127:0] Spaces = {16{8'h20}};

   state_e       state_q, state_d;
   logic [127:0] line1_q, line1_d, line2_q, line2_d;
   logic         ack0_q, ack0_d, ack1_q, ack1_d, drv_start_q, drv_start_d;
   logic         owner_q, owner_d, last_grant_q, last_grant_d;
   logic         hold_active_q, hold_active_d, timeout_err_q, timeout_err_d;
   logic [7:0]   acc_cnt_q, acc_cnt_d;
   logic [25:0]  hold_cnt_q, hold_cnt_d;
   logic         winner;

   // On a tie the requester that did not win last time takes the grant.
   assign winner = (req0 && req1) ? ~last_grant_q : req1;

   always_comb begin
      state_d       = state_q;
      line1_d       = line1_q;
      line2_d       = line2_q;
      ack0_d        = 1'b0;
      ack1_d        = 1'b0;
      drv_start_d   = 1'b0;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      hold_active_d = hold_active_q;
      timeout_err_d = timeout_err_q;
      acc_cnt_d     = acc_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      case (state_q)
         StIdle: begin
            if (!drv_busy && (req0 || req1)) begin
               line1_d      = winner ? line1_1 : line1_0;
               line2_d      = winner ? line2_1 : line2_0;
               ack0_d       = ~winner;
               ack1_d       = winner;
               drv_start_d  = 1'b1;
               owner_d      = winner;
               last_grant_d = winner;
               state_d      = StStart;
            end
         end
         StStart: begin
            acc_cnt_d = '0;
            state_d   = StWaitAccept;
         end
         StWaitAccept: begin
            if (drv_busy) begin
               state_d = StWaitDone;
            end else begin
               acc_cnt_d = acc_cnt_q + 8'd1;
               if (acc_cnt_d == 8'(ACCEPT_TIMEOUT)) begin
                  timeout_err_d = 1'b1;
                  hold_cnt_d    = '0;
                  hold_active_d = 1'b1;
                  state_d       = StHold;
               end
            end
         end
         StWaitDone: begin
            if (!drv_busy) begin
               hold_cnt_d    = '0;
               hold_active_d = 1'b1;
               state_d       = StHold;
            end
         end
         StHold: begin
            if (hold_cnt_q == 26'(HOLD_CYCLES - 1)) begin
               hold_active_d = 1'b0;
               state_d       = StIdle;
            end else begin
               hold_cnt_d = hold_cnt_q + 26'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         line1_q       <= Spaces;
         line2_q       <= Spaces;
         ack0_q        <= 1'b0;
         ack1_q        <= 1'b0;
         drv_start_q   <= 1'b0;
         owner_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         hold_active_q <= 1'b0;
         timeout_err_q <= 1'b0;
         acc_cnt_q     <= '0;
         hold_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         line1_q       <= line1_d;
         line2_q       <= line2_d;
         ack0_q        <= ack0_d;
         ack1_q        <= ack1_d;
         drv_start_q   <= drv_start_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         hold_active_q <= hold_active_d;
         timeout_err_q <= timeout_err_d;
         acc_cnt_q     <= acc_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

   assign line1       = line1_q;
   assign line2       = line2_q;
   assign ack0        = ack0_q;
   assign ack1        = ack1_q;
   assign drv_start   = drv_start_q;
   assign owner       = owner_q;
   assign hold_active = hold_active_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Bench for lcd_frame_arbiter: randomized frames and driver timing against a
// transaction-level model of grant order, refresh timing and dwell length.
module tb_lcd_frame_arbiter;

   localparam int H = 4;
   localparam int T = 3;
   localparam logic [127:0] Spaces = {16{8'h20}};

   logic         clk = 1'b0, reset = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0, drv_busy = 1'b0;
   logic [127:0] line1_0 = '0, line2_0 = '0, line1_1 = '0, line2_1 = '0;
   logic         ack0, ack1, drv_start, owner, hold_active, timeout_err;
   logic [127:0] line1, line2;

   int           checks = 0, passed = 0;
   int           m_last = 1;
   bit           m_te = 1'b0;
   logic [127:0] exp_l1 = Spaces, exp_l2 = Spaces;

   lcd_frame_arbiter #(.HOLD_CYCLES(H), .ACCEPT_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .line1_0(line1_0), .line2_0(line2_0), .ack0(ack0),
      .req1(req1), .line1_1(line1_1), .line2_1(line2_1), .ack1(ack1),
      .drv_busy(drv_busy), .drv_start(drv_start), .line1(line1), .line2(line2),
      .owner(owner), .hold_active(hold_active), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Fresh lines are only presented while the requester is not already waiting.
   task automatic raise(input int idx);
      if (idx == 0) begin
         if (!req0) begin line1_0 = rnd128(); line2_0 = rnd128(); end
         req0 = 1'b1;
      end else begin
         if (!req1) begin line1_1 = rnd128(); line2_1 = rnd128(); end
         req1 = 1'b1;
      end
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      for (int i = 0; i < cycles; i++) tick();
      m_last = 1; m_te = 1'b0; exp_l1 = Spaces; exp_l2 = Spaces;
      checks++;
      if ({line1, line2} !== {Spaces, Spaces})
         $display("FAIL reset_lines: got %h/%h want all 0x20", line1, line2);
      else passed++;
      checks++;
      if ({ack0, ack1, drv_start, hold_active, timeout_err, owner} !== 6'b0)
         $display("FAIL reset_flags: got ack0/ack1/start/hold/terr/owner=%b want 000000",
                  {ack0, ack1, drv_start, hold_active, timeout_err, owner});
      else passed++;
      reset = 1'b0;
   endtask

   // Grant edge from IDLE: expects the round-robin winner's ack, drv_start and lines.
   task automatic grant(input bit drop);
      int w;
      logic [2:0] e3;
      drv_busy = 1'b0;
      w = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
      exp_l1 = (w == 1) ? line1_1 : line1_0;
      exp_l2 = (w == 1) ? line2_1 : line2_0;
      tick();
      m_last = w;
      e3 = {w == 0, w == 1, 1'b1};
      checks++;
      if ({ack0, ack1, drv_start} !== e3)
         $display("FAIL grant_pulses: got ack0/ack1/start=%b want %b", {ack0, ack1, drv_start}, e3);
      else passed++;
      checks++;
      if (owner !== w[0]) $display("FAIL grant_owner: got %b want %0d", owner, w);
      else passed++;
      checks++;
      if ({line1, line2} !== {exp_l1, exp_l2})
         $display("FAIL grant_lines: got %h/%h want %h/%h", line1, line2, exp_l1, exp_l2);
      else passed++;
      checks++;
      if ({hold_active, timeout_err} !== {1'b0, m_te})
         $display("FAIL grant_flags: got hold/terr=%b want 0%b", {hold_active, timeout_err}, m_te);
      else passed++;
      if (drop) begin
         if (w == 0) req0 = 1'b0; else req1 = 1'b0;
      end
      tick();
      checks++;
      if ({ack0, ack1, drv_start} !== 3'b000)
         $display("FAIL start_clear: got ack0/ack1/start=%b want 000", {ack0, ack1, drv_start});
      else passed++;
   endtask

   // Driver raises busy after d accept cycles for l cycles; d >= T never raises it.
   task automatic run_refresh(input int d, input int l, input bit req1_in_hold);
      bit to;
      int he;
      logic exp_ha;
      to = (d >= T);
      he = to ? T - 1 : d + l;
      for (int i = 0; i <= he + H; i++) begin
         drv_busy = !to && i >= d && i < d + l;
         if (req1_in_hold && i == he + 1) raise(1);
         tick();
         if (to && i >= T - 1) m_te = 1'b1;
         exp_ha = (i >= he) && (i < he + H);
         checks++;
         if ({ack0, ack1, drv_start, hold_active, timeout_err} !== {3'b000, exp_ha, m_te})
            $display("FAIL refresh_c%0d: got ack0/ack1/start/hold/terr=%b want %b", i,
                     {ack0, ack1, drv_start, hold_active, timeout_err}, {3'b000, exp_ha, m_te});
         else passed++;
         checks++;
         if ({line1, line2} !== {exp_l1, exp_l2})
            $display("FAIL refresh_lines_c%0d: got %h/%h want %h/%h", i, line1, line2,
                     exp_l1, exp_l2);
         else passed++;
      end
      drv_busy = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(2);
      tick();
      checks++;
      if ({ack0, ack1, drv_start, hold_active} !== 4'b0)
         $display("FAIL idle_quiet: got %b want 0000", {ack0, ack1, drv_start, hold_active});
      else passed++;
   endtask

   task automatic test_single_grant();
      line1_0 = "HELLO WORLD     ";
      line2_0 = rnd128();
      req0 = 1'b1;
      grant(1'b1);
      checks++;
      if (line1 !== 128'("HELLO WORLD     "))
         $display("FAIL hello_line1: got %h want HELLO WORLD", line1);
      else passed++;
      run_refresh(1, 3, 1'b0);
   endtask

   task automatic test_round_robin();
      do_reset(1);
      raise(0);
      raise(1);
      for (int i = 0; i < 4; i++) begin
         grant(1'b0);
         checks++;
         if (owner !== i[0]) $display("FAIL rr_order_%0d: got owner %b want %0d", i, owner, i % 2);
         else passed++;
         run_refresh($urandom_range(0, T - 1), $urandom_range(1, 3), 1'b0);
      end
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic test_busy_block();
      drv_busy = 1'b1;
      raise(1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({ack1, drv_start} !== 2'b00)
            $display("FAIL busy_block_c%0d: got ack1/start=%b want 00", i, {ack1, drv_start});
         else passed++;
      end
      grant(1'b1);
      run_refresh(0, 2, 1'b0);
   endtask

   task automatic test_timeout();
      raise(0);
      grant(1'b1);
      run_refresh(T, 1, 1'b0);
      raise(1);
      grant(1'b1);
      run_refresh(0, 2, 1'b0);
      run_refresh_boundary();
      do_reset(1);
   endtask

   // Busy arriving on the edge the accept count would expire must not flag an error.
   task automatic run_refresh_boundary();
      raise(0);
      grant(1'b1);
      run_refresh(T - 1, 2, 1'b0);
   endtask

   task automatic test_req_in_hold();
      raise(0);
      grant(1'b1);
      run_refresh(0, 1, 1'b1);
      grant(1'b1);
      run_refresh(0, 1, 1'b0);
   endtask

   task automatic test_reset_mid_hold();
      raise(0);
      grant(1'b1);
      drv_busy = 1'b1;
      tick();
      drv_busy = 1'b0;
      tick();
      checks++;
      if (hold_active !== 1'b1) $display("FAIL mid_hold_entry: got %b want 1", hold_active);
      else passed++;
      do_reset(3);
      raise(0);
      raise(1);
      grant(1'b1);
      run_refresh(0, 1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 16; n++) begin
         int r;
         r = $urandom_range(1, 3);
         if (r[0]) raise(0);
         if (r[1]) raise(1);
         grant(1'b1);
         run_refresh($urandom_range(0, T + 1), $urandom_range(1, 4), 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_single_grant();
      test_round_robin();
      test_busy_block();
      test_timeout();
      test_req_in_hold();
      test_reset_mid_hold();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
